write_fifo: RTL and testbench

WRITE_FIFO -- requirements
Module: write_fifo

---
 rtl/write_fifo.sv | 161 ++++++++++++++++
 tb/tb_write_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/write_fifo.sv
`timescale 1ns/1ps
// write_fifo: buffers producer writes in a circular FIFO and drains them onto a
// simple strobe/ack write bus, one transfer per cycle when ack_i is held high.
//
// Optional feature macro: WRITE_FIFO_TIMEOUT_EN
//   When defined, an entry left unacknowledged for TIMEOUT_CYCLES strobe cycles
//   is dropped, err_o pulses, and the FSM proceeds as if the entry were acked.
//   When undefined, the bus waits for ack_i forever and err_o is tied low.
//
// Ports:
//   clk_i     in   1            system clock, rising edge
//   rst_i     in   1            asynchronous active-high reset
//   wr_en_i   in   1            push strobe, one entry per high cycle
//   wr_adr_i  in   8            address of pushed entry
//   wr_dat_i  in   8            data of pushed entry
//   full_o    out  1            FIFO holds 2^DEPTH_LOG2 entries
//   count_o   out  DEPTH_LOG2+1 stored entries, excluding the one on the bus
//   ovf_o     out  1            one-cycle pulse after a dropped push
//   adr_o     out  8            bus address
//   dat_o     out  8            bus write data
//   stb_o     out  1            bus strobe
//   we_o      out  1            bus write enable (same as stb_o)
//   ack_i     in   1            bus acknowledge
//   err_o     out  1            one-cycle pulse after an ack timeout
module write_fifo #(
    parameter int DEPTH_LOG2     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [7:0]            wr_adr_i,
    input  logic [7:0]            wr_dat_i,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  ovf_o,
    output logic [7:0]            adr_o,
    output logic [7:0]            dat_o,
    output logic                  stb_o,
    output logic                  we_o,
    input  logic                  ack_i,
    output logic                  err_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {IDLE, STROBE} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]     count_q;
    logic [7:0]              adr_q, dat_q;
    logic                    ovf_q;
    logic                    push, pop, ack_eff, timeout;

    assign full_o  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    // Full is judged on the registered count, so a push into a full FIFO is
    // dropped even if a pop happens on the same edge.
    assign push    = wr_en_i && !full_o;
    assign count_o = count_q;
    assign stb_o   = (state_q == STROBE);
    assign we_o    = stb_o;
    assign adr_o   = adr_q;
    assign dat_o   = dat_q;
    assign ovf_o   = ovf_q;
    assign ack_eff = ack_i || timeout;

`ifdef WRITE_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          err_q;

    // Counter value equals completed strobe cycles of the current entry, so the
    // timeout fires at the end of the TIMEOUT_CYCLES-th cycle without ack.
    assign timeout = (state_q == STROBE) && !ack_i &&
                     (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state_q != STROBE || ack_i || timeout)
                tmo_cnt_q <= '0;
            else
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign err_o              = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                if (ack_eff) begin
                    if (count_q != '0)
                        pop = 1'b1;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr_q] <= {wr_adr_i, wr_dat_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= wr_en_i && full_o;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                {adr_q, dat_q} <= mem[rd_ptr_q];
                rd_ptr_q       <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_write_fifo.sv
`timescale 1ns/1ps
// Directed bench for write_fifo. Inputs change 1 ns after each rising edge;
// bus transfers are scored at the falling edge before the acking rising edge.
module tb_write_fifo;

    logic        tb_clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_adr, wr_dat;
    logic        full_o;
    logic [4:0]  count_o;
    logic        ovf_o;
    logic [7:0]  adr_o, dat_o;
    logic        stb_o, we_o;
    logic        ack;
    logic        err_o;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] exp_q[$];
    bit          track = 1'b1;

    always #5 tb_clk = ~tb_clk;

    write_fifo #(
        .DEPTH_LOG2     (4),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk_i    (tb_clk),
        .rst_i    (rst),
        .wr_en_i  (wr_en),
        .wr_adr_i (wr_adr),
        .wr_dat_i (wr_dat),
        .full_o   (full_o),
        .count_o  (count_o),
        .ovf_o    (ovf_o),
        .adr_o    (adr_o),
        .dat_o    (dat_o),
        .stb_o    (stb_o),
        .we_o     (we_o),
        .ack_i    (ack),
        .err_o    (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (wr_en && track)
            exp_q.push_back({wr_adr, wr_dat});
        @(negedge tb_clk);
        if (stb_o && ack) begin
            chk("sb_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                chk("sb_order", {adr_o, dat_o}, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
        @(posedge tb_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] d);
        wr_en  = 1'b1;
        wr_adr = a;
        wr_dat = d;
        tick();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_adr = '0; wr_dat = '0; ack = 1'b0;
        repeat (2) @(posedge tb_clk);
        #1;
        chk("rst_stb",   stb_o,   0);
        chk("rst_we",    we_o,    0);
        chk("rst_adr",   adr_o,   0);
        chk("rst_dat",   dat_o,   0);
        chk("rst_count", count_o, 0);
        chk("rst_full",  full_o,  0);
        chk("rst_ovf",   ovf_o,   0);
        chk("rst_err",   err_o,   0);
        rst = 1'b0;

        // Single push with ack held high; ack while idle must be ignored.
        ack = 1'b1;
        tick();
        chk("idle_ack_stb", stb_o, 0);
        push(8'h12, 8'hA5);
        wr_en = 1'b0;
        chk("t1_count", count_o, 1);
        chk("t1_stb_pre", stb_o, 0);
        tick();
        chk("t1_stb", stb_o, 1);
        chk("t1_we",  we_o,  1);
        chk("t1_adr", adr_o, 8'h12);
        chk("t1_dat", dat_o, 8'hA5);
        chk("t1_count0", count_o, 0);
        tick();
        chk("t1_stb_off", stb_o, 0);
        chk("t1_we_off",  we_o,  0);
        chk("t1_adr_hold", adr_o, 8'h12);
        chk("t1_sb_empty", exp_q.size(), 0);

        // Fill: one entry on the bus plus 16 stored, then an overflowing push.
        ack = 1'b0;
        for (int i = 0; i < 17; i++)
            push(8'(8'h20 + i), 8'(8'h80 + i));
        chk("t2_count", count_o, 16);
        chk("t2_full",  full_o,  1);
        chk("t2_ovf0",  ovf_o,   0);
        chk("t2_bus_adr", adr_o, 8'h20);
        track = 1'b0;
        push(8'hEE, 8'hEE);
        track = 1'b1;
        wr_en = 1'b0;
        chk("t2_ovf",  ovf_o,   1);
        chk("t2_count_ovf", count_o, 16);
        tick();
        chk("t2_ovf_clr", ovf_o, 0);
        chk("t2_full_hold", full_o, 1);
        ack = 1'b1;
        tick();
        chk("t2_count_drain", count_o, 15);
        chk("t2_full_clr", full_o, 0);
        repeat (16) tick();
        chk("t2_stb_end", stb_o, 0);
        chk("t2_sb_empty", exp_q.size(), 0);

        // Delayed ack: bus stays stable for 5 cycles.
        ack = 1'b0;
        push(8'h51, 8'h61);
        push(8'h52, 8'h62);
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stb_hold", stb_o, 1);
            chk("t3_adr_hold", adr_o, 8'h51);
            chk("t3_dat_hold", dat_o, 8'h61);
        end
        ack = 1'b1;
        tick();
        chk("t3_adr_next", adr_o, 8'h52);
        chk("t3_dat_next", dat_o, 8'h62);
        tick();
        chk("t3_stb_end", stb_o, 0);
        chk("t3_sb_empty", exp_q.size(), 0);

        // Reset mid-strobe with 3 entries queued.
        ack = 1'b0;
        for (int i = 0; i < 4; i++)
            push(8'(8'h90 + i), 8'(8'hC0 + i));
        wr_en = 1'b0;
        chk("t4_count", count_o, 3);
        chk("t4_stb", stb_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_rst_stb",   stb_o,   0);
        chk("t4_rst_count", count_o, 0);
        chk("t4_rst_adr",   adr_o,   0);
        chk("t4_rst_dat",   dat_o,   0);
        @(posedge tb_clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_no_stb", stb_o, 0);
        end

        // Steady-state push+pop with 8 stored entries.
        ack = 1'b0;
        for (int i = 0; i < 9; i++)
            push(8'(8'h40 + i), 8'(8'h10 + i));
        chk("t5_count_start", count_o, 8);
        ack = 1'b1;
        for (int i = 0; i < 100; i++) begin
            push(8'($urandom), 8'($urandom));
            chk("t5_count_steady", count_o, 8);
        end
        wr_en = 1'b0;
        repeat (9) tick();
        chk("t5_stb_end", stb_o, 0);
        chk("t5_sb_empty", exp_q.size(), 0);

`ifdef WRITE_FIFO_TIMEOUT_EN
        // No ack: first entry times out after 10 strobe cycles.
        ack = 1'b0;
        push(8'h71, 8'h81);
        push(8'h72, 8'h82);
        wr_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("t6_adr_wait", adr_o, 8'h71);
            chk("t6_err_low", err_o, 0);
        end
        tick();
        chk("t6_err", err_o, 1);
        chk("t6_stb", stb_o, 1);
        chk("t6_adr_next", adr_o, 8'h72);
        chk("t6_dat_next", dat_o, 8'h82);
        tick();
        chk("t6_err_clr", err_o, 0);
        void'(exp_q.pop_front());
        ack = 1'b1;
        tick();
        chk("t6_stb_end", stb_o, 0);
        chk("t6_sb_empty", exp_q.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
